svf_sequencer: RTL and testbench

- Time-multiplexes one shared multiplier across CHANNELS state-variable filter lanes.
- On each sample_clk rising edge, issues OPS multiply steps per channel in fixed order over a valid/ready request and result-valid return.
- Emits a one-cycle commit strobe so all channel outputs update together.
- Sits between the sample-rate clock and the shared multiplier/state RAM of the filter core.

---
 rtl/svf_sequencer_if.sv | 17 +
 rtl/svf_sequencer.sv | 117 +++++++++++
 tb/tb_svf_sequencer.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/svf_sequencer_if.sv
// Request/return handshake between the sequencer and the shared multiplier.
interface svf_sequencer_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned OPS      = 5
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ST_W = (OPS > 1) ? $clog2(OPS) : 1;

  logic            op_valid;
  logic            op_ready;
  logic [CH_W-1:0] op_ch;
  logic [ST_W-1:0] op_step;
  logic            res_valid;

  modport master (output op_valid, op_ch, op_step, input op_ready, res_valid);
  modport slave  (input op_valid, op_ch, op_step, output op_ready, res_valid);
endinterface

// File: rtl/svf_sequencer.sv
// Sequences CHANNELS x OPS multiply steps through one shared multiplier per
// sample_clk rising edge, then pulses commit so all lanes update together.
module svf_sequencer #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned OPS      = 5,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_clk,
  svf_sequencer_if.master   bus,
  output logic              busy,
  output logic              commit,
  output logic              overrun,
  output logic              timeout_err
);
  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ST_W  = (OPS > 1) ? $clog2(OPS) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, COMMIT} state_t;

  state_t           state;
  logic             prev;
  logic             pending;
  logic [CNT_W-1:0] wait_cnt;
  logic             start_edge;
  logic             last_step;
  logic             last_ch;

  assign start_edge = sample_clk & ~prev;
  assign last_step  = (bus.op_step == ST_W'(OPS - 1));
  assign last_ch    = (bus.op_ch == CH_W'(CHANNELS - 1));

  // prev resets high so a sample_clk already high at release is not an edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      prev         <= 1'b1;
      pending      <= 1'b0;
      wait_cnt     <= '0;
      bus.op_valid <= 1'b0;
      bus.op_ch    <= '0;
      bus.op_step  <= '0;
      busy         <= 1'b0;
      commit       <= 1'b0;
      overrun      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      prev   <= sample_clk;
      commit <= 1'b0;

      // One edge may be queued behind a running pass; a second one is lost.
      if (start_edge && (state != IDLE)) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (start_edge || pending) begin
            state        <= ISSUE;
            pending      <= 1'b0;
            busy         <= 1'b1;
            bus.op_valid <= 1'b1;
            bus.op_ch    <= '0;
            bus.op_step  <= '0;
          end
        end

        ISSUE: begin
          if (bus.op_ready) begin
            state        <= WAIT;
            bus.op_valid <= 1'b0;
            wait_cnt     <= '0;
          end
        end

        WAIT: begin
          if (bus.res_valid) begin
            if (!last_step) begin
              bus.op_step  <= bus.op_step + ST_W'(1);
              bus.op_valid <= 1'b1;
              state        <= ISSUE;
            end else if (!last_ch) begin
              bus.op_step  <= '0;
              bus.op_ch    <= bus.op_ch + CH_W'(1);
              bus.op_valid <= 1'b1;
              state        <= ISSUE;
            end else begin
              commit <= 1'b1;
              state  <= COMMIT;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Abort the pass without committing partial results.
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            bus.op_ch   <= '0;
            bus.op_step <= '0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        COMMIT: begin
          busy        <= 1'b0;
          bus.op_ch   <= '0;
          bus.op_step <= '0;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_svf_sequencer.sv
// Bench for svf_sequencer: vector table, directed corner passes and random
// handshake traffic, all checked against a transaction-level model.
module tb_svf_sequencer;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned OPS      = 5;
  localparam int unsigned TIMEOUT  = 64;
  localparam int          N        = CHANNELS * OPS;
  localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned ST_W     = (OPS > 1) ? $clog2(OPS) : 1;
  localparam int unsigned VW       = 5 + CH_W + ST_W;
  localparam int          LOG      = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sample_clk = 1'b1;
  logic busy, commit, overrun, timeout_err;

  svf_sequencer_if #(.CHANNELS(CHANNELS), .OPS(OPS)) bus ();

  svf_sequencer #(.CHANNELS(CHANNELS), .OPS(OPS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .bus(bus),
    .busy(busy), .commit(commit), .overrun(overrun), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: request index into the flattened (channel, step) order plus flags.
  bit m_prev, m_active, m_req, m_commit, m_pend, m_ovr, m_tmo;
  int m_idx, m_wait;

  task automatic model_reset();
    m_prev = 1'b1; m_active = 0; m_req = 0; m_commit = 0;
    m_pend = 0; m_ovr = 0; m_tmo = 0; m_idx = 0; m_wait = 0;
  endtask

  task automatic model_step();
    bit rise;
    rise = sample_clk && !m_prev;
    m_prev = sample_clk;
    if (!m_active) begin
      if (rise || m_pend) begin
        m_active = 1; m_req = 1; m_idx = 0; m_pend = 0;
      end
    end else begin
      if (rise) begin
        if (m_pend) m_ovr = 1; else m_pend = 1;
      end
      if (m_commit) begin
        m_commit = 0; m_active = 0; m_idx = 0;
      end else if (m_req) begin
        if (bus.op_ready) begin m_req = 0; m_wait = 0; end
      end else if (bus.res_valid) begin
        m_idx++;
        if (m_idx == N) m_commit = 1; else m_req = 1;
      end else if (m_wait == TIMEOUT - 1) begin
        m_tmo = 1; m_active = 0; m_idx = 0;
      end else begin
        m_wait++;
      end
    end
  endtask

  function automatic logic [VW-1:0] model_vec();
    int k;
    k = (m_idx >= N) ? N - 1 : m_idx;
    return {(m_active && m_req && !m_commit), CH_W'(k / OPS), ST_W'(k % OPS),
            m_active, m_commit, m_ovr, m_tmo};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.op_valid, bus.op_ch, bus.op_step, busy, commit, overrun, timeout_err};
  endfunction

  task automatic check_vec(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%b expected=%b (valid,ch,step,busy,commit,ovr,tmo)",
               name, $time, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick(input string name);
    @(posedge clk);
    model_step();
    #1;
    check_vec(name, dut_vec(), model_vec());
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    check_vec("reset", dut_vec(), '0);
    @(negedge clk);
    rst = 1'b1;
    sample_clk = 1'b0; bus.op_ready = 1'b0; bus.res_valid = 1'b0;
    tick("prime");
    tick("prime");
  endtask

  // Per-run observations.
  int commit_first, commit_cnt, tmo_tick, tmo_busy, acc_drop, stall_seen, stall_bad;
  bit busy_log[LOG];
  bit valid_log[LOG];
  int acc_q[$];

  task automatic run(input string name, input int ncyc, input int stall_idx, input int drop_idx,
                     input int edge_a, input int edge_b, input bit rnd);
    int  stall_n, lat;
    bit  prev_tmo;
    stall_n = 0; lat = 0;
    commit_first = -1; commit_cnt = 0; tmo_tick = -1; tmo_busy = -1; acc_drop = -1;
    stall_seen = 0; stall_bad = 0;
    acc_q.delete();
    prev_tmo = timeout_err;
    for (int i = 0; i < ncyc; i++) begin
      bit awaiting, issuing, in_stall, sc, rdy, res;
      awaiting = m_active && !m_req && !m_commit;
      issuing  = m_active && m_req && !m_commit;
      sc  = (i == 0) || (i == edge_a) || (i == edge_b) || (rnd && $urandom_range(0, 24) == 0);
      rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_stall = issuing && (m_idx == stall_idx) && (stall_n < 7);
      if (in_stall) begin rdy = 1'b0; stall_n++; end
      if (awaiting) begin
        lat--;
        res = (lat == 0);
      end else begin
        res = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      end
      if (issuing && rdy) begin
        acc_q.push_back(int'(bus.op_ch) * OPS + int'(bus.op_step));
        if (m_idx == drop_idx) begin lat = 1000; acc_drop = i; end
        else if (rnd) lat = ($urandom_range(0, 49) == 0) ? 1000 : $urandom_range(1, 4);
        else lat = 1;
      end
      sample_clk = sc; bus.op_ready = rdy; bus.res_valid = res;
      tick(name);
      if (commit) begin
        if (commit_first < 0) commit_first = i;
        commit_cnt++;
      end
      if (in_stall) begin
        stall_seen++;
        if (!(bus.op_valid === 1'b1 && bus.op_ch == 1 && bus.op_step == 2)) stall_bad++;
      end
      if (timeout_err && !prev_tmo && tmo_tick < 0) begin tmo_tick = i; tmo_busy = busy; end
      prev_tmo = timeout_err;
      if (i < LOG) begin busy_log[i] = busy; valid_log[i] = bus.op_valid; end
    end
    sample_clk = 1'b0; bus.op_ready = 1'b0; bus.res_valid = 1'b0;
  endtask

  function automatic int order_errors(input int count);
    int bad;
    bad = 0;
    for (int k = 0; k < count; k++)
      if (k >= acc_q.size() || acc_q[k] != k) bad++;
    return bad;
  endfunction

  typedef struct {
    bit sc, rdy, res;
    bit valid; int ch; int step; bit busy; bit commit;
  } vec_t;

  vec_t tbl[18];

  initial begin
    bus.op_ready = 1'b0;
    bus.res_valid = 1'b0;
    tbl = '{
      '{1,0,0, 0,0,0,0,0}, '{1,0,0, 0,0,0,0,0}, '{1,0,0, 0,0,0,0,0}, '{1,0,0, 0,0,0,0,0},
      '{1,0,0, 0,0,0,0,0}, '{1,0,0, 0,0,0,0,0}, '{1,0,0, 0,0,0,0,0}, '{1,0,0, 0,0,0,0,0},
      '{1,0,0, 0,0,0,0,0}, '{1,0,0, 0,0,0,0,0},
      '{0,0,0, 0,0,0,0,0},
      '{1,0,0, 1,0,0,1,0},
      '{0,0,0, 1,0,0,1,0},
      '{0,1,0, 0,0,0,1,0},
      '{0,0,1, 1,0,1,1,0},
      '{0,1,1, 0,0,1,1,0},
      '{0,0,0, 0,0,1,1,0},
      '{0,0,1, 1,0,2,1,0}
    };

    // Release reset with sample_clk high, then walk the table.
    #1;
    model_reset();
    check_vec("reset_hold", dut_vec(), '0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      sample_clk = tbl[i].sc; bus.op_ready = tbl[i].rdy; bus.res_valid = tbl[i].res;
      tick("tbl_model");
      check_vec("tbl", dut_vec(),
                {tbl[i].valid, CH_W'(tbl[i].ch), ST_W'(tbl[i].step), tbl[i].busy, tbl[i].commit, 2'b00});
    end

    do_reset();
    run("pass", 48, -1, -1, -1, -1, 0);
    check_int("pass_commit_cycle", commit_first, 2 * N);
    check_int("pass_commit_count", commit_cnt, 1);
    check_int("pass_busy_at_commit", busy_log[2 * N], 1);
    check_int("pass_busy_after", busy_log[2 * N + 1], 0);
    check_int("pass_order", order_errors(N), 0);

    run("stall", 56, OPS + 2, -1, -1, -1, 0);
    check_int("stall_cycles", stall_seen, 7);
    check_int("stall_stable", stall_bad, 0);
    check_int("stall_commit_cycle", commit_first, 2 * N + 7);
    check_int("stall_order", order_errors(N), 0);

    run("pend", 90, -1, -1, 10, -1, 0);
    check_int("pend_idle_gap", busy_log[2 * N + 1], 0);
    check_int("pend_restart", valid_log[2 * N + 2], 1);
    check_int("pend_overrun", overrun, 0);
    check_int("pend_commits", commit_cnt, 2);

    run("ovr", 90, -1, -1, 10, 20, 0);
    check_int("ovr_flag", overrun, 1);
    check_int("ovr_commits", commit_cnt, 2);

    run("tmo", 200, -1, 2 * OPS + 3, -1, -1, 0);
    check_int("tmo_latency", tmo_tick - acc_drop, TIMEOUT);
    check_int("tmo_busy", tmo_busy, 0);
    check_int("tmo_no_commit", commit_cnt, 0);
    run("after_tmo", 48, -1, -1, -1, -1, 0);
    check_int("after_tmo_commit", commit_cnt, 1);
    check_int("tmo_sticky", timeout_err, 1);

    // Reset lands mid-WAIT; nothing may commit afterwards without a new edge.
    run("rst_wait", 6, -1, -1, -1, -1, 0);
    check_int("rst_in_wait", (m_active && !m_req) ? 1 : 0, 1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_vec("rst_async", dut_vec(), '0);
    @(negedge clk);
    rst = 1'b1;
    commit_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      sample_clk = 1'b0; bus.op_ready = 1'b1; bus.res_valid = 1'b1;
      tick("rst_after");
      if (commit) commit_cnt++;
    end
    check_int("rst_no_commit", commit_cnt, 0);

    run("rand", 3000, -1, -1, -1, -1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
